classifier_frame_scheduler: RTL
===============================

Name: classifier_frame_scheduler

Overview:
- Sequences image frames from a pixel stream into ClassifierPipeline and returns tagged predictions.
- Owns a two-bank ping-pong frame buffer of 784 pixels per bank. Drives the classifier's input_valid register handshake and serves its input RAM port.
- Collects 4-bit predictions from the classifier output stream and pairs each with the tag of the frame that produced it.

Parameters:
PIXELS, 784, pixels per frame; legal range 2..1023.
PIX_W, 8, pixel width.
TAG_W, 8, frame tag width.
TAGQ_DEPTH, 4, depth of the in-flight tag queue; power of two.

Ports:
clk  in  1  clock; all logic on posedge.
reset  in  1  synchronous, active-low reset.
pix_in_data  in  PIX_W  incoming pixel.
pix_in_valid  in  1  pixel valid.
pix_in_last  in  1  marks the final pixel of a frame.
pix_in_ready  out  1  scheduler accepts the pixel this cycle.
classifier_input_valid_write_en  in  1  classifier writes its input_valid register.
classifier_input_valid_write_data  in  8  written value; only bit 0 is used.
classifier_input_valid_read_data  out  8  value is {7'b0, read bank full}.
classifier_input_address_a  in  10  classifier pixel address.
classifier_input_read_data_a  out  16  value is {zero pad, pixel}; 1-cycle latency.
classifier_output  in  4  prediction from the classifier.
classifier_output_valid  in  1  prediction valid.
classifier_output_ready  out  1  scheduler accepts the prediction.
result_data  out  4  prediction.
result_tag  out  TAG_W  tag of the classified frame.
result_valid  out  1  result valid.
result_ready  in  1  downstream accepts the result.
frame_error  out  1  one-cycle error pulse.
frames_done  out  16  count of accepted results; wraps.

Behaviour:
- Reset (reset==0 at posedge) clears:
  - bank full flags, write bank (wr_bank=0), read bank (rd_bank=0), pixel count, tag counter, tag queue;
  - result_valid, frame_error, frames_done, classifier_input_read_data_a.
- After reset: pix_in_ready=1, read_data=0.
- Reset mid-frame discards all buffered frames and in-flight tags.

Write side:
- pix_in_ready = ~full[wr_bank].
- On a pixel transfer (valid & ready), store the pixel at bank[wr_bank][count] and increment count.
- Commit happens on the transfer where count==PIXELS-1:
  - set full[wr_bank]; latch the tag counter into bank_tag[wr_bank]; increment the tag counter; toggle wr_bank; count<=0.
  - If pix_in_last==0 on this transfer, pulse frame_error; the frame is still committed.
- pix_in_last=1 on a transfer with count<PIXELS-1 (early last):
  - the pixel is written, then count<=0; the bank is not marked full (frame discarded); pulse frame_error; the tag counter is unchanged.

Classifier input side:
- classifier_input_valid_read_data = {7'b0, full[rd_bank]}; combinational from registers.
- write_en with write_data[0]==0 is a release:
  - if full[rd_bank]: clear full[rd_bank], push bank_tag[rd_bank] to the tag queue, toggle rd_bank;
  - if the bank is already empty: no state change, pulse frame_error.
- write_en with write_data[0]==1: no effect.
- A release and a write-side commit may occur in the same cycle. They target different banks; both take effect.
- If the tag queue is full at a release, the release is stalled: the bank stays full and frame_error pulses. Software must not exceed TAGQ_DEPTH frames in flight.
- classifier_input_read_data_a is registered one cycle after the address as {8'b0, bank[rd_bank][addr]}.
  - Address >= PIXELS returns 0.
  - Reads are legal regardless of the full flag.

Output side:
- classifier_output_ready = ~result_valid | result_ready.
- On a classifier transfer:
  - result_data <= classifier_output; result_tag <= tag queue head; pop the queue; result_valid <= 1.
  - If the queue is empty: result_tag <= all-ones and frame_error pulses.
- result_valid clears on a result_ready transfer unless a new result loads in the same cycle.
- frames_done increments on each result_valid & result_ready.
- The tag queue supports push and pop in the same cycle; occupancy is then unchanged.

Throughput:
- One pixel per cycle.
- A frame may fill while the other bank is being classified.

Test Plan:
1. Reset release, then stream 784 pixels (value = index mod 256, last on the 784th) -> full[0]=1, read_data=8'h01, pix_in_ready=1. Address 5 returns 16'h0005 one cycle later; address 800 returns 0.
2. Stream three back-to-back frames with no release -> pix_in_ready drops after the 1568th pixel and the third frame stalls. A release (write_en, data 0) resumes it; the tags pushed are 0, then 1.
3. pix_in_last on pixel 100 -> frame_error pulses one cycle, no bank becomes full, and a following full frame receives tag 0.
4. Two frames released, then the classifier returns predictions 7 and 3 with result_ready low for 5 cycles -> classifier_output_ready=0 while held. Results delivered are (7, tag 0) then (3, tag 1); frames_done=2.
5. Release while the read bank is empty, and a classifier output with an empty tag queue -> frame_error pulses each time. The second case produces result_tag=8'hFF; no other state changes.
6. Assert reset mid-frame at pixel 400 with one bank full -> all flags clear, read_data=0, frames_done=0. The next full frame lands in bank 0 with tag 0.

Source files
------------

// File: rtl/classifier_frame_scheduler.sv
// classifier_frame_scheduler: ping-pong frame buffer feeding ClassifierPipeline and tagging its predictions
module classifier_frame_scheduler #(
  parameter int PIXELS     = 784,
  parameter int PIX_W      = 8,
  parameter int TAG_W      = 8,
  parameter int TAGQ_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PIX_W-1:0]  pix_in_data,
  input  logic              pix_in_valid,
  input  logic              pix_in_last,
  output logic              pix_in_ready,
  input  logic              classifier_input_valid_write_en,
  input  logic [7:0]        classifier_input_valid_write_data,
  output logic [7:0]        classifier_input_valid_read_data,
  input  logic [9:0]        classifier_input_address_a,
  output logic [15:0]       classifier_input_read_data_a,
  input  logic [3:0]        classifier_output,
  input  logic              classifier_output_valid,
  output logic              classifier_output_ready,
  output logic [3:0]        result_data,
  output logic [TAG_W-1:0]  result_tag,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              frame_error,
  output logic [15:0]       frames_done
);
  localparam int CW = $clog2(PIXELS);
  localparam int QW = TAGQ_DEPTH > 1 ? $clog2(TAGQ_DEPTH) : 1;
  logic [PIX_W-1:0] mem [2][PIXELS];
  logic [TAG_W-1:0] bank_tag [2];
  logic [TAG_W-1:0] tq [TAGQ_DEPTH];
  logic [1:0]       full, full_n;
  logic             wr_bank, rd_bank;
  logic [CW-1:0]    count;
  logic [TAG_W-1:0] tag_ctr;
  logic [QW-1:0]    wp, rp;
  logic [QW:0]      occ;
  logic xfer, commit, early, rel, rel_ok, tq_full, tq_empty, c_xfer, pop, err;
  logic unused_ok;
  assign unused_ok = &{1'b0, classifier_input_valid_write_data[7:1]};
  assign pix_in_ready = ~full[wr_bank];
  assign classifier_input_valid_read_data = {7'b0, full[rd_bank]};
  assign classifier_output_ready = ~result_valid | result_ready;
  always_comb begin
    xfer     = pix_in_valid & pix_in_ready;
    commit   = xfer & (count == CW'(PIXELS - 1));
    early    = xfer & pix_in_last & ~commit;
    rel      = classifier_input_valid_write_en & ~classifier_input_valid_write_data[0];
    tq_full  = occ == (QW+1)'(TAGQ_DEPTH);
    tq_empty = occ == '0;
    rel_ok   = rel & full[rd_bank] & ~tq_full;
    c_xfer   = classifier_output_valid & classifier_output_ready;
    pop      = c_xfer & ~tq_empty;
    err      = (commit & ~pix_in_last) | early | (rel & ~rel_ok) | (c_xfer & tq_empty);
  end
  // release and commit never hit the same bank: one needs it full, the other empty
  always_comb begin
    full_n = full;
    if (rel_ok) full_n[rd_bank] = 1'b0;
    if (commit) full_n[wr_bank] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (xfer) mem[wr_bank][count] <= pix_in_data;
    if (commit) bank_tag[wr_bank] <= tag_ctr;
    if (rel_ok) tq[wp] <= bank_tag[rd_bank];
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      full                         <= '0;
      wr_bank                      <= 1'b0;
      rd_bank                      <= 1'b0;
      count                        <= '0;
      tag_ctr                      <= '0;
      wp                           <= '0;
      rp                           <= '0;
      occ                          <= '0;
      result_valid                 <= 1'b0;
      result_data                  <= '0;
      result_tag                   <= '0;
      frame_error                  <= 1'b0;
      frames_done                  <= '0;
      classifier_input_read_data_a <= '0;
    end else begin
      full        <= full_n;
      frame_error <= err;
      classifier_input_read_data_a <= classifier_input_address_a < 10'(PIXELS) ?
        {{(16-PIX_W){1'b0}}, mem[rd_bank][classifier_input_address_a[CW-1:0]]} : 16'h0;
      count <= (commit | early) ? '0 : xfer ? count + 1'b1 : count;
      if (commit) begin
        tag_ctr <= tag_ctr + 1'b1;
        wr_bank <= ~wr_bank;
      end
      if (rel_ok) begin
        wp      <= wp + 1'b1;
        rd_bank <= ~rd_bank;
      end
      if (pop) rp <= rp + 1'b1;
      occ <= occ + (QW+1)'(rel_ok) - (QW+1)'(pop);
      if (c_xfer) begin
        result_data  <= classifier_output;
        result_tag   <= tq_empty ? '1 : tq[rp];
        result_valid <= 1'b1;
      end else if (result_ready) result_valid <= 1'b0;
      if (result_valid & result_ready) frames_done <= frames_done + 1'b1;
    end
  end
endmodule
